decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly downstream of the instruction-fetch stage; consumes InstrD, PCD and PCPlus4D from the IF/ID register.
- Decodes an RV32I subset (lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal) into control signals.
- Contains the 32x32 register file with writeback port and write-through bypass, plus the immediate extender.
- Registers everything into the ID/EX pipeline register with flush support for the execute stage.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count; x0 hardwired to zero.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- InstrD  in  32  instruction from IF/ID register
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  load bubble into ID/EX
- Rs1D, Rs2D  out  5 each  combinational source indices (instr[19:15], instr[24:20]) for hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data
- Rs1E, Rs2E, RdE  out  5 each  registered register indices
- IllegalE  out  1  registered unsupported-opcode/funct flag

Behaviour:
- Reset: every E-side output is 0 and all 32 registers are cleared.
- Latency: exactly 1 cycle from D inputs to E outputs.
- ID/EX priority: reset > FlushE > capture. Flush loads all E-side outputs with 0. A bubble has all controls 0, so it has no architectural side effects.
- Main decoder, opcode -> RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump:
  - 0000011 lw: 1/00/1/0/01/0/00/0
  - 0100011 sw: 0/01/1/1/00/0/00/0
  - 0110011 R: 1/xx/0/0/00/0/10/0
  - 1100011 beq: 0/10/0/0/00/1/01/0
  - 0010011 I-ALU: 1/00/1/0/00/0/10/0
  - 1101111 jal: 1/11/0/0/10/0/00/1
- ALU decoder:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 by funct3: 000 -> sub if {op[5],funct7[5]}==11, else add; 010 -> slt; 110 -> or; 111 -> and.
- Illegal instruction: any other opcode, or other funct3 with ALUOp 10, or beq with funct3 != 000. Registers IllegalE=1 with all controls 0; data fields are still captured.
- Immediates, sign-extended from instr[31]:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Register file:
  - Write on rising edge when RegWriteW=1 and RdW!=0; writes to x0 are ignored and reads of x0 return 0.
  - Reads are combinational with bypass: if RegWriteW=1, RdW!=0 and RdW matches Rs1D/Rs2D, the read returns ResultW in the same cycle.
- Simultaneous events:
  - A writeback in the same cycle as FlushE still updates the register file.
  - Reset in the same cycle as a writeback: reset wins and the register file stays cleared.
- RdE = instr[11:7] for all opcodes; consumers gate it with RegWriteE.

Test Plan:
- Reset asserted 2 cycles with InstrD=0x00700293 -> all E outputs 0; after deassert, next edge gives RegWriteE=1, ALUSrcE=1, ImmExtE=0x00000007, RdE=5, ALUControlE=000.
- InstrD=0xFFC2A303 (lw x6,-4(x5)) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, Rs1E=5, RdE=6.
- InstrD=0xFE000CE3 (beq x0,x0,-8), PCD=0x00000020 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, PCE=0x00000020.
- RegWriteW=1, RdW=5, ResultW=0x0000002A in the same cycle as InstrD=0x005283B3 (add x7,x5,x5) -> next edge RD1E=RD2E=0x0000002A; a later read of x5 also gives 0x2A.
- RegWriteW=1, RdW=0, ResultW=0xDEADBEEF, then read x0 -> RD1E=0.
- FlushE=1 with a valid R-type, and separately InstrD=0x0000007F -> first gives all E outputs 0; second gives IllegalE=1 with all controls 0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: RV32I-subset control decoder, immediate extender, 32x32
// register file with write-through bypass, and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            IllegalE
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Everything the execute stage consumes; a bubble is simply all zeros.
  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctl;
    logic            illegal;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_idx;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd_idx = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  logic       reg_write, alu_src, mem_write, branch, jump, op_bad;
  logic [1:0] imm_src, result_src, alu_op;

  // Main decoder: opcode to raw control word.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    op_bad     = 1'b0;
    case (opcode)
      OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      OP_SW:   begin imm_src = 2'b01; alu_src = 1'b1; mem_write = 1'b1; end
      OP_R:    begin reg_write = 1'b1; alu_op = 2'b10; end
      OP_BEQ:  begin imm_src = 2'b10; branch = 1'b1; alu_op = 2'b01;
                     op_bad = (funct3 != 3'b000); end
      OP_IALU: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      OP_JAL:  begin reg_write = 1'b1; imm_src = 2'b11; result_src = 2'b10; jump = 1'b1; end
      default: op_bad = 1'b1;
    endcase
  end

  logic [2:0] alu_ctl;
  logic       funct_bad;

  // ALU decoder: ALUOp plus funct fields to ALU operation.
  always_comb begin
    alu_ctl   = ALU_ADD;
    funct_bad = 1'b0;
    case (alu_op)
      2'b00:   alu_ctl = ALU_ADD;
      2'b01:   alu_ctl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctl = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctl = ALU_SLT;
          3'b110:  alu_ctl = ALU_OR;
          3'b111:  alu_ctl = ALU_AND;
          default: funct_bad = 1'b1;
        endcase
      end
    endcase
  end

  logic [XLEN-1:0] imm_ext;

  // Immediate extender, sign taken from instr[31].
  always_comb begin
    case (imm_src)
      2'b00:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      2'b01:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    endcase
  end

  logic [XLEN-1:0] rf_q [NREG];
  logic            wb_en;

  assign wb_en = RegWriteW && (RdW != 5'd0);

  // Register file write port; reset clears every entry and beats a writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the architectural state must start at zero, so this array is reset
      // explicitly; that forces flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[RdW] <= ResultW;
    end
  end

  logic [XLEN-1:0] rd1, rd2;

  // Combinational reads with write-through bypass; x0 always reads zero.
  always_comb begin
    if (Rs1D == 5'd0)                 rd1 = '0;
    else if (wb_en && (RdW == Rs1D))  rd1 = ResultW;
    else                              rd1 = rf_q[Rs1D];
    if (Rs2D == 5'd0)                 rd2 = '0;
    else if (wb_en && (RdW == Rs2D))  rd2 = ResultW;
    else                              rd2 = rf_q[Rs2D];
  end

  idex_t idex_d, idex_q;
  logic  illegal;

  assign illegal = op_bad || funct_bad;

  // Assemble the next ID/EX word; an illegal instruction keeps its data but no controls.
  always_comb begin
    idex_d            = '0;
    idex_d.illegal    = illegal;
    idex_d.reg_write  = reg_write  & ~illegal;
    idex_d.mem_write  = mem_write  & ~illegal;
    idex_d.jump       = jump       & ~illegal;
    idex_d.branch     = branch     & ~illegal;
    idex_d.alu_src    = alu_src    & ~illegal;
    idex_d.result_src = illegal ? 2'b00 : result_src;
    idex_d.alu_ctl    = illegal ? 3'b000 : alu_ctl;
    idex_d.rd1        = rd1;
    idex_d.rd2        = rd2;
    idex_d.imm        = imm_ext;
    idex_d.pc         = PCD;
    idex_d.pc4        = PCPlus4D;
    idex_d.rs1        = Rs1D;
    idex_d.rs2        = Rs2D;
    idex_d.rd         = rd_idx;
  end

  // ID/EX register: reset, then flush to a bubble, else capture.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (reset || FlushE) idex_q <= '0;
    else                 idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_ctl;
  assign IllegalE    = idex_q.illegal;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instruction-level reference model checked every
// cycle, directed literal checks, then randomized instruction streams.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .IllegalE(IllegalE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_LW, M_SW, M_ADD, M_SUB, M_AND, M_OR, M_SLT,
                M_ADDI, M_ANDI, M_ORI, M_SLTI, M_BEQ, M_JAL, M_ILL} mn_t;

  typedef struct {
    logic        rw, mw, jmp, br, asrc, ill, imm_ok;
    logic [1:0]  rsrc;
    logic [2:0]  actl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  function automatic mn_t classify(input logic [31:0] i);
    logic [2:0] f3 = i[14:12];
    case (i[6:0])
      7'h03: return M_LW;
      7'h23: return M_SW;
      7'h33: case (f3)
               3'd0: return i[30] ? M_SUB : M_ADD;
               3'd2: return M_SLT;
               3'd6: return M_OR;
               3'd7: return M_AND;
               default: return M_ILL;
             endcase
      7'h13: case (f3)
               3'd0: return M_ADDI;
               3'd2: return M_SLTI;
               3'd6: return M_ORI;
               3'd7: return M_ANDI;
               default: return M_ILL;
             endcase
      7'h63: return (f3 == 3'd0) ? M_BEQ : M_ILL;
      7'h6F: return M_JAL;
      default: return M_ILL;
    endcase
  endfunction

  logic [31:0] mrf [32];
  exp_t        m;
  bit          model_valid = 0;

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{rw:0, mw:0, jmp:0, br:0, asrc:0, ill:0, imm_ok:1, rsrc:0, actl:0,
          rd1:0, rd2:0, imm:0, pc:0, pc4:0, rs1:0, rs2:0, rd:0};
    return e;
  endfunction

  function automatic exp_t predict(input logic [31:0] i, input logic [31:0] pc,
                                   input logic [31:0] pc4);
    exp_t e = zero_exp();
    mn_t  k = classify(i);
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.pc = pc; e.pc4 = pc4;
    e.rd1 = (e.rs1 == 0) ? 32'd0 : mrf[e.rs1];
    e.rd2 = (e.rs2 == 0) ? 32'd0 : mrf[e.rs2];
    e.ill  = (k == M_ILL);
    e.rw   = k inside {M_LW, M_ADD, M_SUB, M_AND, M_OR, M_SLT,
                       M_ADDI, M_ANDI, M_ORI, M_SLTI, M_JAL};
    e.mw   = (k == M_SW);
    e.br   = (k == M_BEQ);
    e.jmp  = (k == M_JAL);
    e.asrc = k inside {M_LW, M_SW, M_ADDI, M_ANDI, M_ORI, M_SLTI};
    e.rsrc = (k == M_LW) ? 2'd1 : (k == M_JAL) ? 2'd2 : 2'd0;
    e.actl = (k inside {M_SUB, M_BEQ})  ? 3'd1 :
             (k inside {M_AND, M_ANDI}) ? 3'd2 :
             (k inside {M_OR, M_ORI})   ? 3'd3 :
             (k inside {M_SLT, M_SLTI}) ? 3'd5 : 3'd0;
    e.imm_ok = 1;
    if (k inside {M_LW, M_ADDI, M_ANDI, M_ORI, M_SLTI})
      e.imm = {{20{i[31]}}, i[31:20]};
    else if (k == M_SW)
      e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
    else if (k == M_BEQ)
      e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    else if (k == M_JAL)
      e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    else
      e.imm_ok = 0;
    return e;
  endfunction

  // Model update: architectural effect of each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) mrf[r] = 32'd0;
      m = zero_exp();
    end else begin
      if (RegWriteW && RdW != 0) mrf[RdW] = ResultW;
      m = FlushE ? zero_exp() : predict(InstrD, PCD, PCPlus4D);
    end
    model_valid = 1;
  end

  // Compare process: mid-cycle, DUT against model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("Rs1D", 32'(Rs1D), 32'(InstrD[19:15]));
      check("Rs2D", 32'(Rs2D), 32'(InstrD[24:20]));
      check("RegWriteE", 32'(RegWriteE), 32'(m.rw));
      check("MemWriteE", 32'(MemWriteE), 32'(m.mw));
      check("JumpE", 32'(JumpE), 32'(m.jmp));
      check("BranchE", 32'(BranchE), 32'(m.br));
      check("ALUSrcE", 32'(ALUSrcE), 32'(m.asrc));
      check("ResultSrcE", 32'(ResultSrcE), 32'(m.rsrc));
      check("ALUControlE", 32'(ALUControlE), 32'(m.actl));
      check("IllegalE", 32'(IllegalE), 32'(m.ill));
      check("RD1E", RD1E, m.rd1);
      check("RD2E", RD2E, m.rd2);
      if (m.imm_ok) check("ImmExtE", ImmExtE, m.imm);
      check("PCE", PCE, m.pc);
      check("PCPlus4E", PCPlus4E, m.pc4);
      check("Rs1E", 32'(Rs1E), 32'(m.rs1));
      check("Rs2E", 32'(Rs2E), 32'(m.rs2));
      check("RdE", 32'(RdE), 32'(m.rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 9);
    logic [2:0] f3s [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
    case (k)
      0: begin r[6:0] = 7'h03; r[14:12] = 3'd2; end
      1: begin r[6:0] = 7'h23; r[14:12] = 3'd2; end
      2, 3: begin
        r[6:0] = 7'h33;
        r[31:25] = {1'b0, r[30], 5'b0};
        if ($urandom_range(0, 7) != 0) r[14:12] = f3s[$urandom_range(0, 3)];
      end
      4, 5: begin
        r[6:0] = 7'h13;
        if ($urandom_range(0, 7) != 0) r[14:12] = f3s[$urandom_range(0, 3)];
      end
      6: begin
        r[6:0] = 7'h63;
        if ($urandom_range(0, 3) != 0) r[14:12] = 3'd0;
      end
      7: r[6:0] = 7'h6F;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1; InstrD = 32'h00700293; PCD = 32'h0; PCPlus4D = 32'h4;
    RegWriteW = 0; RdW = 0; ResultW = 0; FlushE = 0;

    // Reset held two cycles, then addi x5,x0,7.
    cyc();
    check("rst1 RegWriteE", 32'(RegWriteE), 32'd0);
    check("rst1 ImmExtE", ImmExtE, 32'd0);
    cyc();
    check("rst2 RdE", 32'(RdE), 32'd0);
    check("rst2 ALUSrcE", 32'(ALUSrcE), 32'd0);
    reset = 0;
    cyc();
    check("addi RegWriteE", 32'(RegWriteE), 32'd1);
    check("addi ALUSrcE", 32'(ALUSrcE), 32'd1);
    check("addi ImmExtE", ImmExtE, 32'h00000007);
    check("addi RdE", 32'(RdE), 32'd5);
    check("addi ALUControlE", 32'(ALUControlE), 32'd0);

    // lw x6,-4(x5)
    InstrD = 32'hFFC2A303;
    cyc();
    check("lw ImmExtE", ImmExtE, 32'hFFFFFFFC);
    check("lw ResultSrcE", 32'(ResultSrcE), 32'd1);
    check("lw Rs1E", 32'(Rs1E), 32'd5);
    check("lw RdE", 32'(RdE), 32'd6);

    // beq x0,x0,-8 at PC 0x20
    InstrD = 32'hFE000CE3; PCD = 32'h20; PCPlus4D = 32'h24;
    cyc();
    check("beq BranchE", 32'(BranchE), 32'd1);
    check("beq ALUControlE", 32'(ALUControlE), 32'd1);
    check("beq ImmExtE", ImmExtE, 32'hFFFFFFF8);
    check("beq PCE", PCE, 32'h20);

    // add x7,x5,x5 with same-cycle writeback of x5 (bypass), then plain read
    InstrD = 32'h005283B3; RegWriteW = 1; RdW = 5; ResultW = 32'h2A;
    cyc();
    check("byp RD1E", RD1E, 32'h2A);
    check("byp RD2E", RD2E, 32'h2A);
    RegWriteW = 0; ResultW = 32'h0;
    cyc();
    check("rf RD1E", RD1E, 32'h2A);

    // writes to x0 are dropped
    InstrD = 32'h000003B3; RegWriteW = 1; RdW = 0; ResultW = 32'hDEADBEEF;
    cyc();
    check("x0 byp RD1E", RD1E, 32'd0);
    RegWriteW = 0;
    cyc();
    check("x0 RD1E", RD1E, 32'd0);

    // flush of a valid R-type, with a writeback of x7 in the same cycle
    InstrD = 32'h005283B3; PCD = 32'h40; PCPlus4D = 32'h44; FlushE = 1;
    RegWriteW = 1; RdW = 7; ResultW = 32'h99;
    cyc();
    check("flush RegWriteE", 32'(RegWriteE), 32'd0);
    check("flush RD1E", RD1E, 32'd0);
    check("flush PCE", PCE, 32'd0);
    check("flush RdE", 32'(RdE), 32'd0);
    FlushE = 0; RegWriteW = 0;
    InstrD = 32'h00700033; // add x0,x0,x7
    cyc();
    check("flush-wb RD2E", RD2E, 32'h99);

    // unsupported opcode
    InstrD = 32'h0000007F;
    cyc();
    check("ill IllegalE", 32'(IllegalE), 32'd1);
    check("ill RegWriteE", 32'(RegWriteE), 32'd0);
    check("ill MemWriteE", 32'(MemWriteE), 32'd0);
    check("ill ALUSrcE", 32'(ALUSrcE), 32'd0);
    check("ill ResultSrcE", 32'(ResultSrcE), 32'd0);

    // reset wins over a same-cycle writeback
    reset = 1; RegWriteW = 1; RdW = 5; ResultW = 32'h55;
    cyc();
    reset = 0; RegWriteW = 0; InstrD = 32'h005283B3;
    cyc();
    check("rst-wb RD1E", RD1E, 32'd0);

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      InstrD    = rand_instr();
      PCD       = $urandom & 32'hFFFF_FFFC;
      PCPlus4D  = PCD + 32'd4;
      RegWriteW = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: RdW = InstrD[19:15];
        1: RdW = InstrD[24:20];
        2: RdW = 5'd0;
        default: RdW = 5'($urandom);
      endcase
      ResultW = $urandom;
      FlushE  = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      cyc();
    end

    reset = 0; FlushE = 0; RegWriteW = 0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
